// File: rtl/seq_detect_frame_ctrl_pkg.sv
// Shared types and constants for the framed serial pattern detector.
// Imported by the controller top level.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_detect_frame_ctrl_window.sv
// Sliding bit history plus fill level for the pattern matcher.
// The match output is combinational from the stored history and the incoming bit.
module pattern_window #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_shift_en,
  input  logic i_bit_in,
  output logic o_match
);

  localparam int FW = $clog2(PAT_W + 1);

  logic [PAT_W-2:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic [PAT_W-1:0] w_win;

  assign w_win = {r_hist, i_bit_in};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift_en) begin
      r_hist <= w_win[PAT_W-2:0];
      if (r_fill != FW'(PAT_W))
        r_fill <= r_fill + 1'b1;
    end
  end

  assign o_match = i_shift_en
                && (r_fill >= FW'(PAT_W - 1))
                && (w_win == PATTERN);

endmodule

// File: rtl/seq_detect_frame_ctrl.sv
// Frame controller: accepts frame_len bits, counts pattern matches,
// records the first match index and pulses done at end of frame.
module seq_detect_frame_ctrl
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
  parameter int               LEN_W   = 10,
  parameter int               CNT_W   = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_frame_len,
  input  logic             i_bit_in,
  input  logic             i_bit_valid,
  output logic             o_bit_ready,
  output logic             o_busy,
  output logic             o_match_pulse,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_first_found,
  output logic [LEN_W-1:0] o_first_match_idx,
  output logic             o_done
);

  state_e r_state;
  state_e w_next;

  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_idx;
  logic [CNT_W-1:0] r_count;
  logic             r_found;
  logic [LEN_W-1:0] r_first_idx;
  logic             r_pulse;

  logic w_accept;
  logic w_last;
  logic w_launch;
  logic w_match;

  assign w_accept = (r_state == S_RUN) && i_bit_valid;
  assign w_last   = w_accept && (r_remaining == LEN_W'(1));
  assign w_launch = (r_state == S_IDLE) && i_start;

  pattern_window #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_window (
    .i_clk      (i_clock),
    .i_rst_n    (i_reset),
    .i_clear    (w_launch),
    .i_shift_en (w_accept),
    .i_bit_in   (i_bit_in),
    .o_match    (w_match)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start)
          w_next = (i_frame_len != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (w_last)
          w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Results hold from DONE until the next accepted start clears them.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_remaining <= '0;
      r_idx       <= '0;
      r_count     <= '0;
      r_found     <= 1'b0;
      r_first_idx <= '0;
      r_pulse     <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (w_launch) begin
        r_remaining <= i_frame_len;
        r_idx       <= '0;
        r_count     <= '0;
        r_found     <= 1'b0;
        r_first_idx <= '0;
      end else if (w_accept) begin
        r_remaining <= r_remaining - 1'b1;
        r_idx       <= r_idx + 1'b1;
        if (w_match) begin
          r_pulse <= 1'b1;
          if (r_count != {CNT_W{1'b1}})
            r_count <= r_count + 1'b1;
          if (!r_found) begin
            r_found     <= 1'b1;
            r_first_idx <= r_idx;
          end
        end
      end
    end
  end

  assign o_bit_ready       = (r_state == S_RUN);
  assign o_busy            = (r_state != S_IDLE);
  assign o_done            = (r_state == S_DONE);
  assign o_match_pulse     = r_pulse;
  assign o_match_count     = r_count;
  assign o_first_found     = r_found;
  assign o_first_match_idx = r_first_idx;

endmodule

// File: tb/tb_seq_detect_frame_ctrl.sv
// Directed bench for the framed pattern detector.
// Each task drives one scenario and checks hand-computed results.
module tb_seq_detect_frame_ctrl;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [9:0] i_frame_len;
  logic       i_bit_in;
  logic       i_bit_valid;
  logic       o_bit_ready;
  logic       o_busy;
  logic       o_match_pulse;
  logic [7:0] o_match_count;
  logic       o_first_found;
  logic [9:0] o_first_match_idx;
  logic       o_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detect_frame_ctrl dut (
    .i_clock           (clk),
    .i_reset           (i_reset),
    .i_start           (i_start),
    .i_frame_len       (i_frame_len),
    .i_bit_in          (i_bit_in),
    .i_bit_valid       (i_bit_valid),
    .o_bit_ready       (o_bit_ready),
    .o_busy            (o_busy),
    .o_match_pulse     (o_match_pulse),
    .o_match_count     (o_match_count),
    .o_first_found     (o_first_found),
    .o_first_match_idx (o_first_match_idx),
    .o_done            (o_done)
  );

  task automatic start_frame(input logic [9:0] len);
    i_start     = 1'b1;
    i_frame_len = len;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic run_bits(
    input  logic [1023:0] bits,
    input  int            n,
    input  int            gap,
    output logic [1023:0] pmask,
    output int            extra,
    output int            rdy_low,
    output int            done_early
  );
    pmask      = '0;
    extra      = 0;
    rdy_low    = 0;
    done_early = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        i_bit_valid = 1'b0;
        @(posedge clk); #1;
        if (o_match_pulse) extra++;
        if (!o_bit_ready) rdy_low++;
        if (o_done) done_early++;
      end
      if (!o_bit_ready) rdy_low++;
      i_bit_in    = bits[i];
      i_bit_valid = 1'b1;
      @(posedge clk); #1;
      i_bit_valid = 1'b0;
      if (o_match_pulse) pmask[i] = 1'b1;
      if (o_done && i != n - 1) done_early++;
    end
  endtask

  task automatic test_reset;
    i_reset     = 1'b0;
    i_start     = 1'b0;
    i_frame_len = '0;
    i_bit_in    = 1'b0;
    i_bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b1;
    total++;
    if ({o_bit_ready, o_busy, o_match_pulse, o_match_count,
         o_first_found, o_first_match_idx, o_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0",
        {o_bit_ready, o_busy, o_match_pulse, o_match_count,
         o_first_found, o_first_match_idx, o_done});
    end
    @(posedge clk); #1;
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b done=%b exp=0/0", o_busy, o_done);
    end
  endtask

  task automatic test_basic(input int gap, input string tag);
    logic [1023:0] pm;
    int ex, rl, de;
    start_frame(10'd7);
    run_bits(1024'(7'b1101101), 7, gap, pm, ex, rl, de);
    total++;
    if (pm[6:0] !== 7'b1001000 || ex != 0) begin
      bad++;
      $display("FAIL %s_pulses got=%b extra=%0d exp=1001000 extra=0",
        tag, pm[6:0], ex);
    end
    total++;
    if (o_done !== 1'b1 || de != 0) begin
      bad++;
      $display("FAIL %s_done got=%b early=%0d exp=1 early=0", tag, o_done, de);
    end
    total++;
    if (o_match_count !== 8'd2 || o_first_found !== 1'b1
        || o_first_match_idx !== 10'd3) begin
      bad++;
      $display("FAIL %s_results cnt=%0d ff=%b idx=%0d exp=2/1/3",
        tag, o_match_count, o_first_found, o_first_match_idx);
    end
    total++;
    if (rl != 0) begin
      bad++;
      $display("FAIL %s_ready low_cycles=%0d exp=0", tag, rl);
    end
    @(posedge clk); #1;
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_match_count !== 8'd2) begin
      bad++;
      $display("FAIL %s_after done=%b busy=%b cnt=%0d exp=0/0/2",
        tag, o_done, o_busy, o_match_count);
    end
  endtask

  task automatic test_zero_len;
    start_frame(10'd0);
    total++;
    if (o_done !== 1'b1 || o_busy !== 1'b1 || o_bit_ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_done done=%b busy=%b rdy=%b exp=1/1/0",
        o_done, o_busy, o_bit_ready);
    end
    total++;
    if (o_match_count !== 8'd0 || o_first_found !== 1'b0
        || o_first_match_idx !== 10'd0) begin
      bad++;
      $display("FAIL zero_results cnt=%0d ff=%b idx=%0d exp=0/0/0",
        o_match_count, o_first_found, o_first_match_idx);
    end
    @(posedge clk); #1;
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_bit_ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_after done=%b busy=%b rdy=%b exp=0/0/0",
        o_done, o_busy, o_bit_ready);
    end
  endtask

  task automatic test_frame_boundary;
    logic [1023:0] pm;
    int ex, rl, de;
    start_frame(10'd3);
    run_bits(1024'(3'b101), 3, 0, pm, ex, rl, de);
    total++;
    if (pm[2:0] !== 3'b000 || o_match_count !== 8'd0 || o_done !== 1'b1) begin
      bad++;
      $display("FAIL boundary_a pulses=%b cnt=%0d done=%b exp=000/0/1",
        pm[2:0], o_match_count, o_done);
    end
    @(posedge clk); #1;
    start_frame(10'd4);
    run_bits(1024'(4'b1101), 4, 0, pm, ex, rl, de);
    total++;
    if (pm[3:0] !== 4'b1000 || o_match_count !== 8'd1
        || o_first_match_idx !== 10'd3) begin
      bad++;
      $display("FAIL boundary_b pulses=%b cnt=%0d idx=%0d exp=1000/1/3",
        pm[3:0], o_match_count, o_first_match_idx);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_start;
    logic [1023:0] pm;
    int ex, rl, de;
    start_frame(10'd4);
    i_start     = 1'b1;
    i_frame_len = 10'd2;
    run_bits(1024'(4'b1101), 4, 0, pm, ex, rl, de);
    total++;
    if (o_done !== 1'b1 || de != 0 || o_match_count !== 8'd1) begin
      bad++;
      $display("FAIL busy_start done=%b early=%0d cnt=%0d exp=1/0/1",
        o_done, de, o_match_count);
    end
    @(posedge clk); #1;
    i_start = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_match_count !== 8'd1) begin
      bad++;
      $display("FAIL start_at_done busy=%b done=%b cnt=%0d exp=0/0/1",
        o_busy, o_done, o_match_count);
    end
  endtask

  task automatic test_saturate;
    logic [1023:0] b;
    logic [1023:0] pm;
    int ex, rl, de, pulses;
    b = '0;
    for (int i = 0; i < 1023; i++) b[i] = (i % 3 != 1);
    start_frame(10'd1023);
    run_bits(b, 1023, 0, pm, ex, rl, de);
    pulses = 0;
    for (int i = 0; i < 1024; i++) if (pm[i]) pulses++;
    total++;
    if (pulses != 340) begin
      bad++;
      $display("FAIL sat_raw got=%0d exp=340", pulses);
    end
    total++;
    if (o_match_count !== 8'd255 || o_first_match_idx !== 10'd3
        || o_done !== 1'b1) begin
      bad++;
      $display("FAIL sat_results cnt=%0d idx=%0d done=%b exp=255/3/1",
        o_match_count, o_first_match_idx, o_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset;
    logic [1023:0] pm;
    int ex, rl, de;
    start_frame(10'd10);
    run_bits(1024'(5'b01101), 5, 0, pm, ex, rl, de);
    total++;
    if (o_match_count !== 8'd1 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre cnt=%0d busy=%b exp=1/1",
        o_match_count, o_busy);
    end
    i_reset = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b1;
    total++;
    if ({o_bit_ready, o_busy, o_match_pulse, o_match_count,
         o_first_found, o_first_match_idx, o_done} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs got=%b exp=0",
        {o_bit_ready, o_busy, o_match_pulse, o_match_count,
         o_first_found, o_first_match_idx, o_done});
    end
    @(posedge clk); #1;
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_nodone done=%b busy=%b exp=0/0", o_done, o_busy);
    end
    test_basic(0, "postrst");
  endtask

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_basic(3, "stall");
    test_zero_len();
    test_frame_boundary();
    test_busy_start();
    test_saturate();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
